lut8_sbox_mapper: RTL and testbench
===================================

Name: lut8_sbox_mapper

Overview:
- Registered 8-bit substitution unit built from 4-input lookup tables.
- Each nibble of the 8-bit input passes through one shared, run-time-programmable 16x4 LUT; the two 4-bit results are concatenated into the 8-bit output.
- Sits between the stimulus/data source and downstream logic as a one-cycle-latency transform stage.
- Power-up and reset table contents are the PRESENT 4-bit S-box.

Parameters:
- DATA_W, 8, input/output width; fixed at 8; other values unsupported.
- NIB_W, 4, LUT address and data width.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  inp is valid this cycle.
- inp  in  8  data to substitute.
- out_valid  out  1  out holds a fresh result.
- out  out  8  substituted data.
- cfg_we  in  1  LUT write enable.
- cfg_addr  in  4  LUT entry to write.
- cfg_data  in  4  new LUT entry value.

Behaviour:
- Table T[0..15] resets to PRESENT S-box: C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2 (hex).
- Lookup: when in_valid=1 at a rising edge, out <= {T[inp[7:4]], T[inp[3:0]]} and out_valid <= 1.
- Latency is exactly 1 cycle. Full throughput: one result per cycle with no stall. There is no backpressure.
- When in_valid=0: out holds its last value and out_valid <= 0.
- Config: when cfg_we=1 at a rising edge, T[cfg_addr] <= cfg_data. Writes are accepted in any cycle.
- Simultaneous write and lookup of the same entry: the lookup uses the old value. The new value is visible from the next cycle.
- Both nibbles use the same table. Writes affect both nibble paths identically.
- Reset (asserted asynchronously, any time including mid-stream):
  - out = 0x00 and out_valid = 0 immediately.
  - T reloads the default S-box.
  - Inputs are ignored while rst=1.
  - The first lookup after deassertion uses the default table.
- No X propagation: all state is reset.

Optional Feature:
- Macro CFG_READBACK_EN.
- Defined:
  - Adds input cfg_raddr[3:0] and output cfg_rdata[3:0].
  - cfg_rdata is registered: cfg_rdata <= T[cfg_raddr] each cycle, 1-cycle latency, reset value 0.
  - Read during a same-address write returns the old value.
- Undefined: those ports do not exist and there is no readback logic. Lookup behaviour is identical in both builds.

Decomposition:
- Shared package lut8_pkg holds:
  - NIB_W and DATA_W constants.
  - A 4-bit nibble typedef.
  - The 16-entry default S-box constant array SBOX_DEFAULT.
- One natural sub-module: lut16x4_2r1w.
  - Holds the 16x4 register table with async reset to SBOX_DEFAULT.
  - One synchronous write port and two combinational read ports.
- The top instantiates lut16x4_2r1w once and adds the output register and valid flag.

Test Plan:
- Reset then in_valid=1, inp=0x00 -> next cycle out=0xCC, out_valid=1. inp=0x12 -> 0x56. inp=0xFF -> 0x22. inp=0xA5 -> 0xF0.
- Back-to-back stream of 20 random bytes with in_valid=1 every cycle -> each out equals the reference S-box pair of the input one cycle earlier; no gaps.
- cfg_we=1, addr=0, data=0x3, then inp=0x00 -> 0x33. In the same cycle as that write, inp=0x00 -> 0xCC (old value).
- in_valid pulses 1,0,0,1 with inp 0x34 then 0x77 -> out=0xB9, out_valid=1; then out holds 0xB9 with out_valid=0 for 2 cycles; then out=0xDD.
- Reprogram entry 5 to 0x1, assert rst asynchronously mid-stream -> out=0x00 and out_valid=0 without waiting for a clock edge. After release, inp=0x55 -> 0x00 (default table restored).
- With CFG_READBACK_EN: write addr 7 = 0x9, read addr 7 -> cfg_rdata=0x9 one cycle later. Read addr 2 after reset -> 0x6.

Source files
------------

// File: rtl/lut8_pkg.sv
// Shared constants, nibble type and the PRESENT S-box used as the reset
// contents of the substitution table.
package lut8_pkg;

  localparam int NIB_W  = 4;
  localparam int DATA_W = 8;

  typedef logic [NIB_W-1:0] nib_t;

  localparam nib_t SBOX_DEFAULT [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

endpackage

// File: rtl/lut16x4_2r1w.sv
// 16x4 register table: one synchronous write port, two combinational read
// ports. Optional third read port when CFG_READBACK_EN is defined.
module lut16x4_2r1w
  import lut8_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic we_i,
  input  nib_t waddr_i,
  input  nib_t wdata_i,
  input  nib_t raddr_a_i,
  input  nib_t raddr_b_i,
  output nib_t rdata_a_o,
  output nib_t rdata_b_o
`ifdef CFG_READBACK_EN
  ,
  input  nib_t raddr_c_i,
  output nib_t rdata_c_o
`endif
);

  nib_t tbl_q [16];

  // Reads see the registered table, so a same-cycle write is seen only
  // from the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) tbl_q[i] <= SBOX_DEFAULT[i];
    end else if (we_i) begin
      tbl_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = tbl_q[raddr_a_i];
  assign rdata_b_o = tbl_q[raddr_b_i];

`ifdef CFG_READBACK_EN
  assign rdata_c_o = tbl_q[raddr_c_i];
`endif

endmodule

// File: rtl/lut8_sbox_mapper.sv
// Registered 8-bit substitution stage: both nibbles go through one shared
// programmable 16x4 LUT. Optional table readback under CFG_READBACK_EN.
module lut8_sbox_mapper
  import lut8_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] inp,
  output logic              out_valid,
  output logic [DATA_W-1:0] out,
  input  logic              cfg_we,
  input  logic [NIB_W-1:0]  cfg_addr,
  input  logic [NIB_W-1:0]  cfg_data
`ifdef CFG_READBACK_EN
  ,
  input  logic [NIB_W-1:0]  cfg_raddr,
  output logic [NIB_W-1:0]  cfg_rdata
`endif
);

  // Valid semantics: in_valid qualifies inp at a rising edge; out_valid is a
  // one-cycle pulse per accepted input. No backpressure exists, so every
  // accepted input produces exactly one result one cycle later.

  nib_t              sub_hi, sub_lo;
  logic [DATA_W-1:0] out_q, out_d;
  logic              valid_q, valid_d;

`ifdef CFG_READBACK_EN
  nib_t rb_data;
  nib_t rdata_q;
`endif

  lut16x4_2r1w u_lut (
    .clk       (clk),
    .rst       (rst),
    .we_i      (cfg_we),
    .waddr_i   (cfg_addr),
    .wdata_i   (cfg_data),
    .raddr_a_i (inp[7:4]),
    .raddr_b_i (inp[3:0]),
    .rdata_a_o (sub_hi),
    .rdata_b_o (sub_lo)
`ifdef CFG_READBACK_EN
    ,
    .raddr_c_i (cfg_raddr),
    .rdata_c_o (rb_data)
`endif
  );

  always_comb begin
    out_d   = out_q;
    valid_d = 1'b0;
    if (in_valid) begin
      out_d   = {sub_hi, sub_lo};
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;

`ifdef CFG_READBACK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rb_data;
  end

  assign cfg_rdata = rdata_q;
`endif

endmodule

// File: tb/tb_lut8_sbox_mapper.sv
// Scoreboard bench for lut8_sbox_mapper: stimulus pushes expected bytes from
// an array-based S-box model; a negedge monitor pops and compares.
module tb_lut8_sbox_mapper;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] inp = '0;
  logic       out_valid;
  logic [7:0] out_s;
  logic       cfg_we = 1'b0;
  logic [3:0] cfg_addr = '0;
  logic [3:0] cfg_data = '0;
`ifdef CFG_READBACK_EN
  logic [3:0] cfg_raddr = '0;
  logic [3:0] cfg_rdata;
`endif

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];
  logic [7:0] hold_exp = 8'h00;
  logic       mon_en = 1'b1;

  logic [3:0] sbox_ref [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
  logic [3:0] ref_tbl [16];

  lut8_sbox_mapper dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .inp       (inp),
    .out_valid (out_valid),
    .out       (out_s),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data)
`ifdef CFG_READBACK_EN
    ,
    .cfg_raddr (cfg_raddr),
    .cfg_rdata (cfg_rdata)
`endif
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #60000;
    errors++;
    checks++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) ref_tbl[i] = sbox_ref[i];
    exp_q.delete();
    hold_exp = 8'h00;
  endtask

  // One clock of stimulus; the expected result uses the table as it stood
  // before this cycle's write.
  task automatic cycle(input logic v, input logic [7:0] d, input logic we,
                       input logic [3:0] a, input logic [3:0] wd);
    in_valid = v;
    inp      = d;
    cfg_we   = we;
    cfg_addr = a;
    cfg_data = wd;
    if (v) exp_q.push_back({ref_tbl[d[7:4]], ref_tbl[d[3:0]]});
    if (we) ref_tbl[a] = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic look(input logic [7:0] d);
    cycle(1'b1, d, 1'b0, 4'h0, 4'h0);
  endtask

  task automatic idle();
    cycle(1'b0, 8'h00, 1'b0, 4'h0, 4'h0);
  endtask

  // Monitor: valid outputs pop the scoreboard, idle cycles must hold.
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", {7'd0, out_valid}, 8'h00);
        end else begin
          hold_exp = exp_q.pop_front();
          chk("out", out_s, hold_exp);
        end
      end else begin
        chk("out_hold", out_s, hold_exp);
      end
    end
  end

  initial begin
    model_reset();
    #1 rst = 1'b1;
    #1;
    chk("reset_out", out_s, 8'h00);
    chk("reset_valid", {7'd0, out_valid}, 8'h00);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Directed lookups from the default table
    look(8'h00);
    look(8'h12);
    look(8'hFF);
    look(8'hA5);
    idle();

    // Back-to-back random stream
    for (int i = 0; i < 20; i++) look(8'($urandom_range(0, 255)));
    idle();

    // Same-cycle write and lookup sees the old entry; next lookup sees new
    cycle(1'b1, 8'h00, 1'b1, 4'h0, 4'h3);
    look(8'h00);
    idle();

    // Valid pulses with hold in between
    look(8'h34);
    idle();
    idle();
    look(8'h77);
    idle();

    // Random stream mixed with random table writes
    for (int i = 0; i < 20; i++)
      cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
            ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)));
    idle();

    // Reprogram entry 5, then reset asynchronously mid-stream
    cycle(1'b0, 8'h00, 1'b1, 4'h5, 4'h1);
    look(8'h55);
    look(8'h5A);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("async_rst_out", out_s, 8'h00);
    chk("async_rst_valid", {7'd0, out_valid}, 8'h00);
    @(posedge clk);
    #2 rst = 1'b0;
    look(8'h55);
    idle();

`ifdef CFG_READBACK_EN
    cfg_raddr = 4'h2;
    idle();
    chk("rb_default", {4'h0, cfg_rdata}, {4'h0, sbox_ref[2]});
    cfg_raddr = 4'h7;
    cycle(1'b0, 8'h00, 1'b1, 4'h7, 4'h9);
    chk("rb_old_on_write", {4'h0, cfg_rdata}, {4'h0, sbox_ref[7]});
    idle();
    chk("rb_new", {4'h0, cfg_rdata}, 8'h09);
`endif

    idle();
    chk("queue_drained", 8'(exp_q.size()), 8'h00);
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
